// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// Port 0 is the CPU load/store unit, port 1 the debug/DMA loader.
interface data_memory_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [1:0]        p0_byte;
    logic              p0_sext;
    logic              p0_ack;
    logic              p0_err;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [1:0]        p1_byte;
    logic              p1_sext;
    logic              p1_ack;
    logic              p1_err;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_byte;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and memory model side
    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata, p0_byte, p0_sext,
        input  p0_ack, p0_err, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_byte, p1_sext,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_we, mem_addr, mem_wdata, mem_byte,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata, p0_byte, p0_sext,
        output p0_ack, p0_err, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_byte, p1_sext,
        output p1_ack, p1_err, p1_rdata,
        output mem_we, mem_addr, mem_wdata, mem_byte,
        input  mem_rdata
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory.
// One transaction every three cycles (IDLE grant, ACCESS, RESP). Load data is
// lane-aligned and sign/zero-extended; misaligned accesses are rejected
// without touching the memory.
module data_memory_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Requests packed per port so grant and command selection index by port
    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [1:0]        sext_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];
    logic [1:0]        byte_vec  [2];

    assign req_vec      = {bus.p1_req,  bus.p0_req};
    assign we_vec       = {bus.p1_we,   bus.p0_we};
    assign sext_vec     = {bus.p1_sext, bus.p0_sext};
    assign addr_vec[0]  = bus.p0_addr;
    assign addr_vec[1]  = bus.p1_addr;
    assign wdata_vec[0] = bus.p0_wdata;
    assign wdata_vec[1] = bus.p1_wdata;
    assign byte_vec[0]  = bus.p0_byte;
    assign byte_vec[1]  = bus.p1_byte;

    // Latched command; only sampled in the IDLE grant cycle
    logic              last_grant_reg;
    logic              cmd_we_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic [DATA_W-1:0] cmd_wdata_reg;
    logic [1:0]        cmd_byte_reg;
    logic              cmd_sext_reg;
    logic              cmd_port_reg;
    logic              cmd_err_reg;

    logic              grant_valid;
    logic              grant_port;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_byte;
    logic              sel_err;

    assign grant_valid = |req_vec;

    // Grant: a lone requester wins; on a tie the port not served last wins
    always_comb begin
        grant_port = req_vec[1];
        if (req_vec == 2'b11) begin
            grant_port = ~last_grant_reg;
        end
    end

    assign sel_addr = addr_vec[grant_port];
    assign sel_byte = byte_vec[grant_port];

    // Misalignment: word needs addr[1:0]==0, half needs addr[0]==0, bytes always fine
    always_comb begin
        sel_err = 1'b0;
        if (sel_byte[1] == 1'b0) begin
            sel_err = (sel_addr[1:0] != 2'b00);
        end else if (sel_byte == 2'b10) begin
            sel_err = sel_addr[0];
        end
    end

    // FSM next state: IDLE -> ACCESS -> RESP -> IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command capture and round-robin pointer update on a grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            cmd_we_reg     <= 1'b0;
            cmd_addr_reg   <= '0;
            cmd_wdata_reg  <= '0;
            cmd_byte_reg   <= 2'b00;
            cmd_sext_reg   <= 1'b0;
            cmd_port_reg   <= 1'b0;
            cmd_err_reg    <= 1'b0;
        end else if (state_reg == IDLE && grant_valid) begin
            last_grant_reg <= grant_port;
            cmd_we_reg     <= we_vec[grant_port];
            cmd_addr_reg   <= sel_addr;
            cmd_wdata_reg  <= wdata_vec[grant_port];
            cmd_byte_reg   <= sel_byte;
            cmd_sext_reg   <= sext_vec[grant_port];
            cmd_port_reg   <= grant_port;
            cmd_err_reg    <= sel_err;
        end
    end

    // Load extraction: pick the addressed lane and extend to a full word
    logic [15:0]       half_lane;
    logic [7:0]        byte_lane;
    logic [DATA_W-1:0] load_word;

    always_comb begin
        half_lane = bus.mem_rdata[15:0];
        byte_lane = bus.mem_rdata[7:0];
        load_word = bus.mem_rdata;
        if (cmd_addr_reg[1]) begin
            half_lane = bus.mem_rdata[31:16];
        end
        case (cmd_addr_reg[1:0])
            2'b00:   byte_lane = bus.mem_rdata[7:0];
            2'b01:   byte_lane = bus.mem_rdata[15:8];
            2'b10:   byte_lane = bus.mem_rdata[23:16];
            default: byte_lane = bus.mem_rdata[31:24];
        endcase
        case (cmd_byte_reg)
            2'b10:   load_word = {{(DATA_W-16){cmd_sext_reg & half_lane[15]}}, half_lane};
            2'b11:   load_word = {{(DATA_W-8){cmd_sext_reg & byte_lane[7]}}, byte_lane};
            default: load_word = bus.mem_rdata;
        endcase
    end

    logic [1:0] ack_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rdata_reg;

            // Per-port load result, updated only by a good load to this port
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (state_reg == ACCESS && cmd_port_reg == 1'(gi)
                             && !cmd_we_reg && !cmd_err_reg) begin
                    rdata_reg <= load_word;
                end
            end

            assign ack_vec[gi] = (state_reg == RESP) && (cmd_port_reg == 1'(gi));
        end
    endgenerate

    assign bus.p0_ack   = ack_vec[0];
    assign bus.p0_err   = ack_vec[0] & cmd_err_reg;
    assign bus.p0_rdata = g_port[0].rdata_reg;
    assign bus.p1_ack   = ack_vec[1];
    assign bus.p1_err   = ack_vec[1] & cmd_err_reg;
    assign bus.p1_rdata = g_port[1].rdata_reg;

    // Memory side is driven from the command registers in every state;
    // the write strobe exists only in ACCESS and never for a rejected access.
    assign bus.mem_we    = (state_reg == ACCESS) & cmd_we_reg & ~cmd_err_reg;
    assign bus.mem_addr  = cmd_addr_reg;
    assign bus.mem_wdata = cmd_wdata_reg;
    assign bus.mem_byte  = cmd_byte_reg;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: a lane-merging memory model,
// a table of single-port transactions and hand-written multi-cycle sequences
// (tie alternation, back-to-back requests, reset during ACCESS).
module tb_data_memory_arbiter;
    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;

    always #5 clk = ~clk;

    data_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: combinational read, write with lane merge at posedge
    logic [31:0] mem [128];
    assign bus.mem_rdata = mem[bus.mem_addr[ADDR_W-1:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
        end else if (bus.mem_we) begin
            case (bus.mem_byte)
                2'b10:   mem[bus.mem_addr[ADDR_W-1:2]][16*bus.mem_addr[1] +: 16] <= bus.mem_wdata[15:0];
                2'b11:   mem[bus.mem_addr[ADDR_W-1:2]][8*bus.mem_addr[1:0] +: 8] <= bus.mem_wdata[7:0];
                default: mem[bus.mem_addr[ADDR_W-1:2]] <= bus.mem_wdata;
            endcase
        end
    end

    // Event monitors (sampled on the falling edge)
    int we_cycles = 0;
    int ack_cnt0  = 0;
    int ack_cnt1  = 0;
    always @(negedge clk) begin
        if (bus.mem_we) we_cycles++;
        if (bus.p0_ack) ack_cnt0++;
        if (bus.p1_ack) ack_cnt1++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_port(input int port, input logic req, input logic we,
                              input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                              input logic [1:0] bm, input logic sext);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr;
            bus.p0_wdata = wdata; bus.p0_byte = bm; bus.p0_sext = sext;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr;
            bus.p1_wdata = wdata; bus.p1_byte = bm; bus.p1_sext = sext;
        end
    endtask

    // One transaction on one port; entered and left just after a rising edge
    task automatic run_txn(input int port, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wdata, input logic [1:0] bm, input logic sext,
                           output logic got_ack, output int lat, output logic err,
                           output logic [31:0] rdata, output int we_seen, output int other_acks);
        int we0, oth0;
        we0  = we_cycles;
        oth0 = (port == 0) ? ack_cnt1 : ack_cnt0;
        got_ack = 1'b0; lat = 0; err = 1'b0; rdata = 32'h0;
        drive_port(port, 1'b1, we, addr, wdata, bm, sext);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if ((port == 0) ? bus.p0_ack : bus.p1_ack) begin
                got_ack = 1'b1;
                lat     = c;
                err     = (port == 0) ? bus.p0_err : bus.p1_err;
                rdata   = (port == 0) ? bus.p0_rdata : bus.p1_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        drive_port(port, 1'b0, 1'b0, '0, 32'h0, 2'b00, 1'b0);
        we_seen    = we_cycles - we0;
        other_acks = ((port == 0) ? ack_cnt1 : ack_cnt0) - oth0;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  bm;
        logic        sext;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_we;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic        got_ack, err;
        logic [31:0] rdata;
        int          lat, we_seen, other_acks;
        int          order [4];
        int          n_acks, t0, t1;

        drive_port(0, 1'b0, 1'b0, '0, 32'h0, 2'b00, 1'b0);
        drive_port(1, 1'b0, 1'b0, '0, 32'h0, 2'b00, 1'b0);

        //            port we  addr     wdata          bm     sext err   rdata          we
        vecs[0]  = '{0, 1'b1, 9'h010, 32'hDEADBEEF, 2'b00, 1'b0, 1'b0, 32'h00000000, 1};
        vecs[1]  = '{0, 1'b0, 9'h010, 32'h0,        2'b00, 1'b0, 1'b0, 32'hDEADBEEF, 0};
        vecs[2]  = '{0, 1'b1, 9'h004, 32'h11223344, 2'b00, 1'b0, 1'b0, 32'hDEADBEEF, 1};
        vecs[3]  = '{0, 1'b1, 9'h005, 32'h000000F0, 2'b11, 1'b0, 1'b0, 32'hDEADBEEF, 1};
        vecs[4]  = '{0, 1'b0, 9'h004, 32'h0,        2'b01, 1'b0, 1'b0, 32'h1122F044, 0};
        vecs[5]  = '{0, 1'b0, 9'h005, 32'h0,        2'b11, 1'b1, 1'b0, 32'hFFFFFFF0, 0};
        vecs[6]  = '{0, 1'b0, 9'h005, 32'h0,        2'b11, 1'b0, 1'b0, 32'h000000F0, 0};
        vecs[7]  = '{1, 1'b1, 9'h004, 32'h8001F044, 2'b00, 1'b0, 1'b0, 32'h00000000, 1};
        vecs[8]  = '{1, 1'b0, 9'h006, 32'h0,        2'b10, 1'b1, 1'b0, 32'hFFFF8001, 0};
        vecs[9]  = '{1, 1'b0, 9'h003, 32'h0,        2'b10, 1'b1, 1'b1, 32'hFFFF8001, 0};
        vecs[10] = '{1, 1'b1, 9'h012, 32'h12345678, 2'b00, 1'b0, 1'b1, 32'hFFFF8001, 0};
        vecs[11] = '{1, 1'b0, 9'h010, 32'h0,        2'b00, 1'b0, 1'b0, 32'hDEADBEEF, 0};
        vecs[12] = '{0, 1'b0, 9'h004, 32'h0,        2'b10, 1'b0, 1'b0, 32'h0000F044, 0};
        vecs[13] = '{1, 1'b0, 9'h007, 32'h0,        2'b11, 1'b1, 1'b0, 32'hFFFFFF80, 0};
        vecs[14] = '{0, 1'b0, 9'h011, 32'h0,        2'b01, 1'b0, 1'b1, 32'h0000F044, 0};
        vecs[15] = '{0, 1'b1, 9'h012, 32'h0000ABCD, 2'b10, 1'b0, 1'b0, 32'h0000F044, 1};
        vecs[16] = '{0, 1'b0, 9'h010, 32'h0,        2'b00, 1'b0, 1'b0, 32'hABCDBEEF, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;
        check("reset_ack", {30'h0, bus.p1_ack, bus.p0_ack}, 32'h0);
        check("reset_err", {30'h0, bus.p1_err, bus.p0_err}, 32'h0);
        check("reset_p0_rdata", bus.p0_rdata, 32'h0);
        check("reset_p1_rdata", bus.p1_rdata, 32'h0);
        check("reset_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("reset_mem_addr", {23'h0, bus.mem_addr}, 32'h0);
        check("reset_mem_wdata", bus.mem_wdata, 32'h0);
        check("reset_mem_byte", {30'h0, bus.mem_byte}, 32'h0);
        $display("reset: outputs checked");

        // Tie from reset: both hold req, grants alternate 0,1,0,1
        drive_port(0, 1'b1, 1'b0, 9'h100, 32'h0, 2'b00, 1'b0);
        drive_port(1, 1'b1, 1'b0, 9'h104, 32'h0, 2'b00, 1'b0);
        n_acks = 0;
        for (int c = 0; c < 30 && n_acks < 4; c++) begin
            @(negedge clk);
            if (bus.p0_ack && bus.p1_ack) check("tie_both_ack", 32'h1, 32'h0);
            if (bus.p0_ack && n_acks < 4) begin order[n_acks] = 0; n_acks++; end
            else if (bus.p1_ack && n_acks < 4) begin order[n_acks] = 1; n_acks++; end
        end
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, '0, 32'h0, 2'b00, 1'b0);
        drive_port(1, 1'b0, 1'b0, '0, 32'h0, 2'b00, 1'b0);
        check("tie_ack_count", n_acks, 4);
        for (int i = 0; i < 4 && i < n_acks; i++) begin
            check($sformatf("tie_order[%0d]", i), order[i], i % 2);
        end
        $display("tie: %0d acks, order %0d %0d %0d %0d", n_acks, order[0], order[1], order[2], order[3]);

        // p1 alone holds req through RESP: re-granted, acks exactly 3 cycles apart
        drive_port(1, 1'b1, 1'b0, 9'h108, 32'h0, 2'b00, 1'b0);
        n_acks = 0; t0 = 0; t1 = 0;
        for (int c = 1; c <= 12 && n_acks < 2; c++) begin
            @(negedge clk);
            if (bus.p0_ack) check("hold_p0_ack", 32'h1, 32'h0);
            if (bus.p1_ack) begin
                if (n_acks == 0) t0 = c; else t1 = c;
                n_acks++;
            end
        end
        @(posedge clk); #1;
        drive_port(1, 1'b0, 1'b0, '0, 32'h0, 2'b00, 1'b0);
        check("hold_ack_count", n_acks, 2);
        check("hold_first_latency", t0, 3);
        check("hold_gap", t1 - t0, 3);
        $display("hold: p1 acks=%0d first=%0d gap=%0d", n_acks, t0, t1 - t0);

        // Table-driven single-port transactions
        for (int v = 0; v < 17; v++) begin
            run_txn(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].bm,
                    vecs[v].sext, got_ack, lat, err, rdata, we_seen, other_acks);
            check($sformatf("v%0d_ack", v), {31'h0, got_ack}, 32'h1);
            check($sformatf("v%0d_latency", v), lat, 3);
            check($sformatf("v%0d_err", v), {31'h0, err}, {31'h0, vecs[v].exp_err});
            check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
            check($sformatf("v%0d_mem_we_cycles", v), we_seen, vecs[v].exp_we);
            check($sformatf("v%0d_other_ack", v), other_acks, 0);
            $display("txn %0d: port=%0d we=%0b addr=0x%03h byte=%02b sext=%0b -> ack=%0b lat=%0d err=%0b rdata=0x%08h we_cycles=%0d",
                     v, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].bm, vecs[v].sext,
                     got_ack, lat, err, rdata, we_seen);
        end
        check("mem_word_0x004", mem[1], 32'h8001F044);
        check("mem_word_0x010", mem[4], 32'hABCDBEEF);

        // Reset asserted during ACCESS of a store to 0x020
        drive_port(0, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D, 2'b00, 1'b0);
        @(negedge clk);   // IDLE grant cycle
        @(negedge clk);   // ACCESS
        check("rst_mid_we_before", {31'h0, bus.mem_we}, 32'h1);
        #2;
        rst = 1'b1;
        drive_port(0, 1'b0, 1'b0, '0, 32'h0, 2'b00, 1'b0);
        #1;
        check("rst_mid_we_drop", {31'h0, bus.mem_we}, 32'h0);
        check("rst_mid_ack", {30'h0, bus.p1_ack, bus.p0_ack}, 32'h0);
        check("rst_mid_p0_rdata", bus.p0_rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        t0 = ack_cnt0 + ack_cnt1;
        repeat (4) @(negedge clk);
        check("rst_mid_no_ack", ack_cnt0 + ack_cnt1 - t0, 0);
        check("rst_mid_mem_untouched", mem[8], 32'h0);
        @(posedge clk); #1;
        $display("reset mid-access: mem_we dropped, no ack, mem[0x020]=0x%08h", mem[8]);

        run_txn(0, 1'b1, 9'h020, 32'h0BADCAFE, 2'b00, 1'b0, got_ack, lat, err, rdata, we_seen, other_acks);
        check("post_rst_store_ack", {31'h0, got_ack}, 32'h1);
        check("post_rst_store_we", we_seen, 1);
        run_txn(0, 1'b0, 9'h020, 32'h0, 2'b00, 1'b0, got_ack, lat, err, rdata, we_seen, other_acks);
        check("post_rst_load_ack", {31'h0, got_ack}, 32'h1);
        check("post_rst_load_latency", lat, 3);
        check("post_rst_load_rdata", rdata, 32'h0BADCAFE);
        $display("post-reset: store+load 0x020 -> ack=%0b rdata=0x%08h", got_ack, rdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
